// File: rtl/fb_rect_writer.sv
// Rectangle-fill write engine for the cell framebuffer: clips each command to the
// framebuffer, optionally waits for a vblank rising edge, then writes one cell per clock.
module fb_rect_writer #(
    parameter int PX_WIDTH  = 160,
    parameter int PX_HEIGHT = 120,
    parameter int ADDR_W    = 16
) (
    input  logic              dclk,
    input  logic              clr,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [7:0]        cmd_x,
    input  logic [7:0]        cmd_y,
    input  logic [7:0]        cmd_w,
    input  logic [7:0]        cmd_h,
    input  logic [2:0]        cmd_code,
    input  logic              cmd_sync,
    input  logic              vblank,
    output logic [ADDR_W-1:0] wmemaddr,
    output logic [2:0]        wmemdata,
    output logic              wmemwe,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_VB = 2'd1,
        FILL    = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam logic [8:0]        X_LIM  = 9'(PX_WIDTH);
    localparam logic [8:0]        Y_LIM  = 9'(PX_HEIGHT);
    localparam logic [ADDR_W-1:0] STRIDE = ADDR_W'(PX_WIDTH);

    // Control state (reset)
    state_t            state_q, state_d;
    logic              vb_q, vb_d;
    logic              wmemwe_q, wmemwe_d;
    logic              done_q, done_d;
    logic              fill_end_q, fill_end_d;
    logic [ADDR_W-1:0] wmemaddr_q, wmemaddr_d;
    logic [2:0]        wmemdata_q, wmemdata_d;

    // Latched command and scan position (no reset needed)
    logic [8:0]        x0_q, x0_d;
    logic [8:0]        xe_q, xe_d;
    logic [8:0]        ye_q, ye_d;
    logic [8:0]        col_q, col_d;
    logic [8:0]        row_q, row_d;
    logic [ADDR_W-1:0] rowbase_q, rowbase_d;
    logic [2:0]        code_q, code_d;

    logic [8:0] x_sum, y_sum, x_clip, y_clip, col_nx, row_nx;
    logic       cmd_empty;

    always_comb begin
        x_sum     = {1'b0, cmd_x} + {1'b0, cmd_w};
        y_sum     = {1'b0, cmd_y} + {1'b0, cmd_h};
        x_clip    = (x_sum > X_LIM) ? X_LIM : x_sum;
        y_clip    = (y_sum > Y_LIM) ? Y_LIM : y_sum;
        cmd_empty = (cmd_w == 8'd0) || (cmd_h == 8'd0) ||
                    ({1'b0, cmd_x} >= X_LIM) || ({1'b0, cmd_y} >= Y_LIM);
        col_nx    = col_q + 9'd1;
        row_nx    = row_q + 9'd1;

        state_d    = state_q;
        vb_d       = vblank;
        wmemwe_d   = 1'b0;
        done_d     = 1'b0;
        fill_end_d = fill_end_q;
        wmemaddr_d = wmemaddr_q;
        wmemdata_d = wmemdata_q;
        x0_d       = x0_q;
        xe_d       = xe_q;
        ye_d       = ye_q;
        col_d      = col_q;
        row_d      = row_q;
        rowbase_d  = rowbase_q;
        code_d     = code_q;

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    x0_d       = {1'b0, cmd_x};
                    col_d      = {1'b0, cmd_x};
                    row_d      = {1'b0, cmd_y};
                    xe_d       = x_clip;
                    ye_d       = y_clip;
                    code_d     = cmd_code;
                    rowbase_d  = ADDR_W'(cmd_y) * STRIDE;
                    fill_end_d = 1'b0;
                    if (cmd_empty) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else if (cmd_sync) begin
                        state_d = WAIT_VB;
                    end else begin
                        state_d = FILL;
                    end
                end
            end
            WAIT_VB: begin
                if (vblank && !vb_q) state_d = FILL;
            end
            FILL: begin
                // The last write is still on the bus in the fill_end cycle; done follows it.
                if (fill_end_q) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else begin
                    wmemwe_d   = 1'b1;
                    wmemdata_d = code_q;
                    wmemaddr_d = rowbase_q + ADDR_W'(col_q);
                    if (col_nx == xe_q) begin
                        col_d      = x0_q;
                        row_d      = row_nx;
                        rowbase_d  = rowbase_q + STRIDE;
                        fill_end_d = (row_nx == ye_q);
                    end else begin
                        col_d = col_nx;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge dclk) begin
        if (!clr) begin
            state_q    <= IDLE;
            vb_q       <= 1'b0;
            wmemwe_q   <= 1'b0;
            done_q     <= 1'b0;
            fill_end_q <= 1'b0;
            wmemaddr_q <= '0;
            wmemdata_q <= '0;
        end else begin
            state_q    <= state_d;
            vb_q       <= vb_d;
            wmemwe_q   <= wmemwe_d;
            done_q     <= done_d;
            fill_end_q <= fill_end_d;
            wmemaddr_q <= wmemaddr_d;
            wmemdata_q <= wmemdata_d;
        end
    end

    always_ff @(posedge dclk) begin
        x0_q      <= x0_d;
        xe_q      <= xe_d;
        ye_q      <= ye_d;
        col_q     <= col_d;
        row_q     <= row_d;
        rowbase_q <= rowbase_d;
        code_q    <= code_d;
    end

    assign cmd_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign wmemwe    = wmemwe_q;
    assign wmemaddr  = wmemaddr_q;
    assign wmemdata  = wmemdata_q;
    assign done      = done_q;

endmodule

// File: tb/tb_fb_rect_writer.sv
// Scoreboard bench for fb_rect_writer: a cell-by-cell reference model queues expected
// writes and done pulses; a negedge monitor pops and compares them with cycle timing.
module tb_fb_rect_writer;

    localparam int W  = 160;
    localparam int H  = 120;
    localparam int AW = 16;

    logic          dclk = 1'b0;
    logic          clr;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [7:0]    cmd_x, cmd_y, cmd_w, cmd_h;
    logic [2:0]    cmd_code;
    logic          cmd_sync;
    logic          vblank;
    logic [AW-1:0] wmemaddr;
    logic [2:0]    wmemdata;
    logic          wmemwe;
    logic          busy;
    logic          done;

    fb_rect_writer #(.PX_WIDTH(W), .PX_HEIGHT(H), .ADDR_W(AW)) dut (
        .dclk(dclk), .clr(clr), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_w(cmd_w), .cmd_h(cmd_h),
        .cmd_code(cmd_code), .cmd_sync(cmd_sync), .vblank(vblank),
        .wmemaddr(wmemaddr), .wmemdata(wmemdata), .wmemwe(wmemwe),
        .busy(busy), .done(done)
    );

    always #5 dclk = ~dclk;

    typedef struct {
        bit is_done;
        int addr;
        int data;
        int due;
    } ev_t;

    ev_t exp_q[$];
    int  cyc     = 0;
    int  n_tests = 0;
    int  n_fail  = 0;
    int  wr_seen = 0;

    initial forever begin
        @(posedge dclk);
        cyc++;
    end

    task automatic check(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: every cell of the requested rectangle that lies on screen, row-major.
    task automatic push_cmd(input int x, input int y, input int w, input int h,
                            input int code, input bit sync, input int acc);
        ev_t e;
        bit  first = 1'b1;
        for (int r = y; r < y + h; r++) begin
            for (int c = x; c < x + w; c++) begin
                if (c < W && r < H) begin
                    e.is_done = 1'b0;
                    e.addr    = r * W + c;
                    e.data    = code;
                    e.due     = (first && !sync) ? acc + 1 : -1;
                    first     = 1'b0;
                    exp_q.push_back(e);
                end
            end
        end
        e.is_done = 1'b1;
        e.addr    = 0;
        e.data    = 0;
        e.due     = first ? acc : -1;
        exp_q.push_back(e);
    endtask

    initial begin : monitor
        bit  got_w, got_d, ok, prev_evt;
        ev_t e;
        prev_evt = 1'b0;
        forever begin
            @(negedge dclk);
            got_w = (wmemwe === 1'b1);
            got_d = (done === 1'b1);
            if (got_w) wr_seen++;
            if (got_w || got_d) begin
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL event: got we=%0b done=%0b addr=%0d at cycle %0d, expected nothing",
                             got_w, got_d, wmemaddr, cyc);
                end else begin
                    e  = exp_q.pop_front();
                    ok = (got_w != got_d) && (got_d == e.is_done) && (e.due < 0 || e.due == cyc);
                    if (got_w && !e.is_done)
                        ok = ok && (int'(wmemaddr) == e.addr) && (int'(wmemdata) == e.data);
                    if (!ok) begin
                        n_fail++;
                        $display("FAIL event: got we=%0b done=%0b addr=%0d data=%0d cycle=%0d, expected %s addr=%0d data=%0d cycle=%0d",
                                 got_w, got_d, wmemaddr, wmemdata, cyc,
                                 e.is_done ? "done" : "write", e.addr, e.data, e.due);
                    end
                end
                prev_evt = got_w;
            end else begin
                if (prev_evt && exp_q.size() > 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL gap: got no output at cycle %0d, expected %s addr=%0d",
                             cyc, exp_q[0].is_done ? "done" : "write", exp_q[0].addr);
                end else if (exp_q.size() > 0 && exp_q[0].due >= 0 && cyc >= exp_q[0].due) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL late: got no output at cycle %0d, expected %s addr=%0d at cycle %0d",
                             cyc, exp_q[0].is_done ? "done" : "write", exp_q[0].addr, exp_q[0].due);
                    exp_q[0].due = -1;
                end
                prev_evt = 1'b0;
            end
        end
    end

    task automatic send(input int x, input int y, input int w, input int h,
                        input int code, input bit sync, output int acc);
        int n = 0;
        @(posedge dclk); #1;
        while (cmd_ready !== 1'b1 && n < 40000) begin
            @(posedge dclk); #1;
            n++;
        end
        if (cmd_ready !== 1'b1) begin
            n_tests++;
            n_fail++;
            $display("FAIL send_ready: got cmd_ready=%0b after %0d cycles, expected 1", cmd_ready, n);
            acc = -1;
            return;
        end
        cmd_x     = 8'(x);
        cmd_y     = 8'(y);
        cmd_w     = 8'(w);
        cmd_h     = 8'(h);
        cmd_code  = 3'(code);
        cmd_sync  = sync;
        cmd_valid = 1'b1;
        acc       = cyc + 1;
        push_cmd(x, y, w, h, code, sync, acc);
        @(posedge dclk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        @(posedge dclk); #1;
        while ((exp_q.size() != 0 || busy !== 1'b0) && n < 30000) begin
            @(posedge dclk); #1;
            n++;
        end
        if (exp_q.size() != 0 || busy !== 1'b0) begin
            n_tests++;
            n_fail++;
            $display("FAIL wait_idle: got %0d pending events busy=%0b, expected 0 and 0",
                     exp_q.size(), busy);
            exp_q.delete();
        end
    endtask

    initial begin
        int acc, a, w0, base, x, y, w, h;
        clr       = 1'b0;
        cmd_valid = 1'b0;
        cmd_x     = '0;
        cmd_y     = '0;
        cmd_w     = '0;
        cmd_h     = '0;
        cmd_code  = '0;
        cmd_sync  = 1'b0;
        vblank    = 1'b0;
        repeat (3) @(posedge dclk);
        #1;
        check("rst_wmemwe", wmemwe, 0);
        check("rst_wmemaddr", wmemaddr, 0);
        check("rst_wmemdata", wmemdata, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_cmd_ready", cmd_ready, 1);
        clr = 1'b1;

        send(2, 3, 3, 2, 4, 1'b0, acc);
        wait_idle();
        check("ready_after_cmd1", cmd_ready, 1);

        send(158, 119, 5, 4, 1, 1'b0, acc);
        send(160, 0, 1, 1, 2, 1'b0, acc);
        wait_idle();

        // Sync: vblank already high at acceptance must not start the fill.
        vblank = 1'b1;
        send(30, 40, 4, 3, 7, 1'b1, acc);
        w0 = wr_seen;
        repeat (10) begin @(posedge dclk); #1; end
        vblank = 1'b0;
        repeat (3) begin @(posedge dclk); #1; end
        check("sync_hold_writes", wr_seen - w0, 0);
        check("sync_hold_busy", busy, 1);
        vblank = 1'b1;
        if (exp_q.size() > 0) exp_q[0].due = cyc + 2;
        wait_idle();
        vblank = 1'b0;

        // Back-to-back with cmd_valid held; B's fields appear while A is busy.
        @(posedge dclk); #1;
        check("b2b_ready_start", cmd_ready, 1);
        cmd_x = 8'd10; cmd_y = 8'd10; cmd_w = 8'd1; cmd_h = 8'd1; cmd_code = 3'd3; cmd_sync = 1'b0;
        cmd_valid = 1'b1;
        a = cyc + 1;
        push_cmd(10, 10, 1, 1, 3, 1'b0, a);
        @(posedge dclk); #1;
        cmd_x = 8'd11; cmd_code = 3'd6;
        push_cmd(11, 10, 1, 1, 6, 1'b0, a + 4);
        check("b2b_ready_fill0", cmd_ready, 0);
        @(posedge dclk); #1;
        check("b2b_ready_fill1", cmd_ready, 0);
        @(posedge dclk); #1;
        check("b2b_ready_done", cmd_ready, 0);
        @(posedge dclk); #1;
        check("b2b_ready_idle", cmd_ready, 1);
        @(posedge dclk); #1;
        cmd_valid = 1'b0;
        wait_idle();

        for (int i = 0; i < 24; i++) begin
            x = $urandom_range(0, 170);
            y = $urandom_range(0, 130);
            if ($urandom_range(0, 7) == 0) begin
                w = $urandom_range(150, 255);
                h = $urandom_range(0, 3);
            end else begin
                w = $urandom_range(0, 12);
                h = $urandom_range(0, 12);
            end
            send(x, y, w, h, $urandom_range(0, 7), 1'b0, acc);
        end
        wait_idle();

        send(0, 0, 160, 120, 0, 1'b0, acc);
        wait_idle();

        // Reset after the fifth write of a 10x1 fill.
        base = wr_seen;
        send(20, 50, 10, 1, 5, 1'b0, acc);
        repeat (5) begin @(posedge dclk); #1; end
        clr = 1'b0;
        @(posedge dclk); #1;
        exp_q.delete();
        check("midrst_wmemwe", wmemwe, 0);
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        @(posedge dclk); #1;
        check("midrst_wmemwe2", wmemwe, 0);
        check("midrst_writes", wr_seen - base, 5);
        clr = 1'b1;
        @(posedge dclk); #1;
        check("midrst_ready", cmd_ready, 1);
        check("midrst_done2", done, 0);
        send(0, 0, 2, 2, 6, 1'b0, acc);
        wait_idle();

        repeat (3) @(posedge dclk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
